// File: rtl/fight_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : fight_engine_if
// Purpose  : Bundles the player-side request/action signals consumed by the
//            fight_engine and the match-state results it publishes.
// Modports : master - player/stimulus side (drives requests, reads results)
//            slave  - fight_engine side (reads requests, drives results)
// Signals  : tick, restart, pN_left_req, pN_right_req, pN_attack_req,
//            pN_action[6:0]          -> into the engine
//            pN_x[9:0], pN_health[7:0], pN_shield[7:0], pN_hit,
//            game_over, winner[1:0]  <- from the engine
// Revision : 1.0 - initial release
// ============================================================================
interface fight_engine_if;
  logic       tick;
  logic       restart;
  logic       p0_left_req;
  logic       p0_right_req;
  logic       p1_left_req;
  logic       p1_right_req;
  logic       p0_attack_req;
  logic       p1_attack_req;
  logic [6:0] p0_action;
  logic [6:0] p1_action;

  logic [9:0] p0_x;
  logic [9:0] p1_x;
  logic [7:0] p0_health;
  logic [7:0] p1_health;
  logic [7:0] p0_shield;
  logic [7:0] p1_shield;
  logic       p0_hit;
  logic       p1_hit;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output tick, restart,
    output p0_left_req, p0_right_req, p1_left_req, p1_right_req,
    output p0_attack_req, p1_attack_req, p0_action, p1_action,
    input  p0_x, p1_x, p0_health, p1_health, p0_shield, p1_shield,
    input  p0_hit, p1_hit, game_over, winner
  );

  modport slave (
    input  tick, restart,
    input  p0_left_req, p0_right_req, p1_left_req, p1_right_req,
    input  p0_attack_req, p1_attack_req, p0_action, p1_action,
    output p0_x, p1_x, p0_health, p1_health, p0_shield, p1_shield,
    output p0_hit, p1_hit, game_over, winner
  );
endinterface
`default_nettype wire

// File: rtl/fight_engine.sv
`default_nettype none
// ============================================================================
// Module   : fight_engine
// Purpose  : Match-state core for a two-player fighter. Owns both fighters'
//            x positions, health and shield; resolves punches, blocks and
//            dodges; declares the winner.
// Ports    : clk   - system clock
//            reset - asynchronous, active-low
//            bus   - fight_engine_if.slave (requests in, match state out)
// Revision : 1.0 - initial release
// ============================================================================
module fight_engine #(
  parameter logic [9:0] X_MIN          = 10'd16,
  parameter logic [9:0] X_MAX          = 10'd624,
  parameter logic [9:0] P0_START       = 10'd160,
  parameter logic [9:0] P1_START       = 10'd480,
  parameter logic [9:0] WALK_STEP      = 10'd4,
  parameter logic [9:0] MIN_GAP        = 10'd32,
  parameter logic [9:0] REACH          = 10'd48,
  parameter logic [7:0] DAMAGE         = 8'd10,
  parameter logic [7:0] SHIELD_COST    = 8'd20,
  parameter logic [7:0] MAX_HP         = 8'd100,
  parameter logic [7:0] RECHARGE_TICKS = 8'd30
) (
  input  logic          clk,
  input  logic          reset,
  fight_engine_if.slave bus
);

  localparam logic [9:0] TWO_STEPS = WALK_STEP << 1;

  typedef enum logic [0:0] {
    FIGHT = 1'b0,
    OVER  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] p0_x_q, p0_x_d, p1_x_q, p1_x_d;
  logic [7:0] p0_hp_q, p0_hp_d, p1_hp_q, p1_hp_d;
  logic [7:0] p0_sh_q, p0_sh_d, p1_sh_q, p1_sh_d;
  logic [7:0] p0_cnt_q, p0_cnt_d, p1_cnt_q, p1_cnt_d;
  logic       p0_hit_q, p0_hit_d, p1_hit_q, p1_hit_d;
  logic [1:0] winner_q, winner_d;

  // Decoded player inputs
  logic       p0_go_l, p0_go_r, p1_go_l, p1_go_r;
  logic       p0_dodge, p1_dodge, p0_block, p1_block;
  logic       p0_atk_ok, p1_atk_ok;
  logic [9:0] gap, slack, p0_in_step, p1_in_step;
  logic [9:0] p0_x_mv, p1_x_mv;

  // Standing/punching/walking bits carry no meaning for match resolution.
  logic unused_action;
  assign unused_action = ^{bus.p0_action[5:4], bus.p0_action[0],
                           bus.p1_action[5:4], bus.p1_action[0]};

  assign p0_go_l  = bus.p0_left_req  & ~bus.p0_right_req;
  assign p0_go_r  = bus.p0_right_req & ~bus.p0_left_req;
  assign p1_go_l  = bus.p1_left_req  & ~bus.p1_right_req;
  assign p1_go_r  = bus.p1_right_req & ~bus.p1_left_req;
  assign p0_dodge = bus.p0_action[3] | bus.p0_action[1];
  assign p1_dodge = bus.p1_action[3] | bus.p1_action[1];
  assign p0_block = bus.p0_action[2];
  assign p1_block = bus.p1_action[2];

  // The invariant guarantees gap >= MIN_GAP, so slack never underflows.
  assign gap   = p1_x_q - p0_x_q;
  assign slack = gap - MIN_GAP;

  // An attack needs the attacker to face the opponent and be within reach.
  assign p0_atk_ok = (state_q == FIGHT) && bus.p0_attack_req &&
                     !bus.p0_action[6] && (gap <= REACH);
  assign p1_atk_ok = (state_q == FIGHT) && bus.p1_attack_req &&
                     bus.p1_action[6] && (gap <= REACH);

  // Inward step sizes, limited so the gap never closes below MIN_GAP.
  // When both close in and the slack is short, p1 takes the odd pixel.
  always_comb begin
    p0_in_step = '0;
    p1_in_step = '0;
    if (p0_go_r && p1_go_l) begin
      if (slack >= TWO_STEPS) begin
        p0_in_step = WALK_STEP;
        p1_in_step = WALK_STEP;
      end else begin
        p0_in_step = slack >> 1;
        p1_in_step = slack - (slack >> 1);
      end
    end else if (p0_go_r) begin
      p0_in_step = (slack < WALK_STEP) ? slack : WALK_STEP;
    end else if (p1_go_l) begin
      p1_in_step = (slack < WALK_STEP) ? slack : WALK_STEP;
    end
  end

  // Outward steps only need the arena clamp.
  always_comb begin
    p0_x_mv = p0_x_q;
    p1_x_mv = p1_x_q;
    if (p0_go_l) begin
      p0_x_mv = (p0_x_q < X_MIN + WALK_STEP) ? X_MIN : p0_x_q - WALK_STEP;
    end else if (p0_go_r) begin
      p0_x_mv = p0_x_q + p0_in_step;
    end
    if (p1_go_r) begin
      p1_x_mv = (p1_x_q > X_MAX - WALK_STEP) ? X_MAX : p1_x_q + WALK_STEP;
    end else if (p1_go_l) begin
      p1_x_mv = p1_x_q - p1_in_step;
    end
  end

  // Next-state and datapath update. Everything reads pre-update (_q) values,
  // so tick, movement and simultaneous attacks compose without ordering.
  always_comb begin
    state_d  = state_q;
    p0_x_d   = p0_x_q;
    p1_x_d   = p1_x_q;
    p0_hp_d  = p0_hp_q;
    p1_hp_d  = p1_hp_q;
    p0_sh_d  = p0_sh_q;
    p1_sh_d  = p1_sh_q;
    p0_cnt_d = p0_cnt_q;
    p1_cnt_d = p1_cnt_q;
    p0_hit_d = 1'b0;
    p1_hit_d = 1'b0;
    winner_d = winner_q;

    if (bus.restart) begin
      state_d  = FIGHT;
      p0_x_d   = P0_START;
      p1_x_d   = P1_START;
      p0_hp_d  = MAX_HP;
      p1_hp_d  = MAX_HP;
      p0_sh_d  = MAX_HP;
      p1_sh_d  = MAX_HP;
      p0_cnt_d = '0;
      p1_cnt_d = '0;
      winner_d = 2'b00;
    end else if (state_q == FIGHT) begin
      if (bus.tick) begin
        p0_x_d = p0_x_mv;
        p1_x_d = p1_x_mv;
        // Recharge only runs while not shielding, so it never collides with
        // a blocked-hit shield deduction in the same cycle.
        if (p0_block) begin
          p0_cnt_d = '0;
        end else if (p0_cnt_q + 8'd1 == RECHARGE_TICKS) begin
          p0_cnt_d = '0;
          if (p0_sh_q < MAX_HP) p0_sh_d = p0_sh_q + 8'd1;
        end else begin
          p0_cnt_d = p0_cnt_q + 8'd1;
        end
        if (p1_block) begin
          p1_cnt_d = '0;
        end else if (p1_cnt_q + 8'd1 == RECHARGE_TICKS) begin
          p1_cnt_d = '0;
          if (p1_sh_q < MAX_HP) p1_sh_d = p1_sh_q + 8'd1;
        end else begin
          p1_cnt_d = p1_cnt_q + 8'd1;
        end
      end

      if (p0_atk_ok && !p1_dodge) begin
        if (p1_block && (p1_sh_q >= SHIELD_COST)) begin
          p1_sh_d = p1_sh_q - SHIELD_COST;
        end else begin
          p1_hp_d  = (p1_hp_q > DAMAGE) ? p1_hp_q - DAMAGE : 8'd0;
          p1_hit_d = 1'b1;
        end
      end

      if (p1_atk_ok && !p0_dodge) begin
        if (p0_block && (p0_sh_q >= SHIELD_COST)) begin
          p0_sh_d = p0_sh_q - SHIELD_COST;
        end else begin
          p0_hp_d  = (p0_hp_q > DAMAGE) ? p0_hp_q - DAMAGE : 8'd0;
          p0_hit_d = 1'b1;
        end
      end

      // winner bit1 = p0 down, bit0 = p1 down: 01 p0 wins, 10 p1, 11 draw.
      if ((p0_hp_d == 8'd0) || (p1_hp_d == 8'd0)) begin
        state_d  = OVER;
        winner_d = {(p0_hp_d == 8'd0), (p1_hp_d == 8'd0)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FIGHT;
      p0_x_q   <= P0_START;
      p1_x_q   <= P1_START;
      p0_hp_q  <= MAX_HP;
      p1_hp_q  <= MAX_HP;
      p0_sh_q  <= MAX_HP;
      p1_sh_q  <= MAX_HP;
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
      p0_hit_q <= 1'b0;
      p1_hit_q <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      p0_x_q   <= p0_x_d;
      p1_x_q   <= p1_x_d;
      p0_hp_q  <= p0_hp_d;
      p1_hp_q  <= p1_hp_d;
      p0_sh_q  <= p0_sh_d;
      p1_sh_q  <= p1_sh_d;
      p0_cnt_q <= p0_cnt_d;
      p1_cnt_q <= p1_cnt_d;
      p0_hit_q <= p0_hit_d;
      p1_hit_q <= p1_hit_d;
      winner_q <= winner_d;
    end
  end

  assign bus.p0_x      = p0_x_q;
  assign bus.p1_x      = p1_x_q;
  assign bus.p0_health = p0_hp_q;
  assign bus.p1_health = p1_hp_q;
  assign bus.p0_shield = p0_sh_q;
  assign bus.p1_shield = p1_sh_q;
  assign bus.p0_hit    = p0_hit_q;
  assign bus.p1_hit    = p1_hit_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.winner    = winner_q;

endmodule
`default_nettype wire
